ibex_csr_rmw_ctrl: RTL

IBEX_CSR_RMW_CTRL -- requirements
Module: ibex_csr_rmw_ctrl

---
 rtl/ibex_csr_rmw_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write sequencer for one CSR, with write masking and integrity-error reporting.
// Write strobe N+2 after accept and response from N+3 (N+2 if no write); one access in flight; response held until rsp_ready_i.
// Optional integrity error counter on err_cnt_o: define IBEX_CSR_RMW_ERRCNT_EN.
module ibex_csr_rmw_ctrl #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] WriteMask = {Width{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [Width-1:0] req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic [Width-1:0] csr_wr_data_o,
    output logic             csr_wr_en_o,
    input  logic [Width-1:0] csr_rd_data_i,
    input  logic             csr_rd_error_i,
    output logic [7:0]       err_cnt_o
);

    typedef enum logic [1:0] {IDLE, SAMPLE, WRITE, RESP} state_e;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    state_e           state_q, state_d;
    logic [1:0]       op_q;
    logic [Width-1:0] operand_q;
    logic [Width-1:0] old_q;
    logic             err_q;
    logic             init_q;
    logic [Width-1:0] new_val;
    logic             accept;

    // init_q keeps req_ready_o low until the first clock after reset release.
    assign accept = (state_q == IDLE) && init_q && req_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OpRead;
            operand_q <= '0;
            old_q     <= '0;
            err_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (accept) begin
                op_q      <= req_op_i;
                operand_q <= req_wdata_i;
            end
            if (state_q == SAMPLE) begin
                old_q <= csr_rd_data_i;
                err_q <= csr_rd_error_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SAMPLE;
            end
            SAMPLE: begin
                // Reads, integrity errors and set/clear with a zero operand skip the write.
                if ((op_q == OpRead) || csr_rd_error_i || (op_q[1] && (operand_q == '0)))
                    state_d = RESP;
                else
                    state_d = WRITE;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        new_val = old_q;
        case (op_q)
            OpWrite: new_val = operand_q;
            OpSet:   new_val = old_q | operand_q;
            OpClear: new_val = old_q & ~operand_q;
            default: new_val = old_q;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE) && init_q;
    assign csr_wr_en_o   = (state_q == WRITE);
    assign csr_wr_data_o = csr_wr_en_o ? ((new_val & WriteMask) | (old_q & ~WriteMask)) : '0;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_rdata_o   = rsp_valid_o ? old_q : '0;
    assign rsp_error_o   = rsp_valid_o & err_q;

`ifdef IBEX_CSR_RMW_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 8'd0;
        end else if ((state_q == SAMPLE) && csr_rd_error_i && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = 8'd0;
`endif

endmodule
